// File: rtl/sc_io_hex_display.sv
// Scans the computer's three output ports round-robin, converts each low byte to
// BCD with a sequential double-dabble engine and drives two 7-segment digits per port.
module sc_io_hex_display #(
    parameter int CONV_BITS = 8,
    parameter int NUM_PORTS = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] out_port0,
    input  logic [31:0] out_port1,
    input  logic [31:0] out_port2,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5,
    output logic [2:0]  ovf,
    output logic        disp_update,
    output logic [1:0]  cur_port
);

    localparam int CNT_W = (CONV_BITS > 1) ? $clog2(CONV_BITS) : 1;
    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(CONV_BITS - 1);
    localparam logic [1:0] LAST_PORT = 2'(NUM_PORTS - 1);

    localparam logic [1:0] LOAD  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] STORE = 2'd2;

    logic [1:0]           state;
    logic [CNT_W-1:0]     counter;
    logic [CONV_BITS-1:0] bin_reg;
    logic [11:0]          bcd_reg;
    logic [11:0]          bcd_adj;
    logic [CONV_BITS-1:0] port_sel;
    logic [6:0]           seg_tens;
    logic [6:0]           seg_ones;
    logic                 hundreds_nz;
    logic                 unused_upper;

    // Only the low byte of each port is shown; the rest is consumed here to keep lint quiet.
    assign unused_upper = ^{out_port0[31:CONV_BITS], out_port1[31:CONV_BITS], out_port2[31:CONV_BITS]};

    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
    endfunction

    always_comb begin
        port_sel = out_port0[CONV_BITS-1:0];
        case (cur_port)
            2'd1:    port_sel = out_port1[CONV_BITS-1:0];
            2'd2:    port_sel = out_port2[CONV_BITS-1:0];
            default: port_sel = out_port0[CONV_BITS-1:0];
        endcase
    end

    // Add-3 correction applied to every BCD nibble before each shift.
    always_comb begin
        bcd_adj = bcd_reg;
        if (bcd_reg[3:0]  >= 4'd5) bcd_adj[3:0]  = bcd_reg[3:0]  + 4'd3;
        if (bcd_reg[7:4]  >= 4'd5) bcd_adj[7:4]  = bcd_reg[7:4]  + 4'd3;
        if (bcd_reg[11:8] >= 4'd5) bcd_adj[11:8] = bcd_reg[11:8] + 4'd3;
    end

    assign seg_tens    = seg(bcd_reg[7:4]);
    assign seg_ones    = seg(bcd_reg[3:0]);
    assign hundreds_nz = (bcd_reg[11:8] != 4'd0);

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= LOAD;
            cur_port    <= 2'd0;
            counter     <= '0;
            bin_reg     <= '0;
            bcd_reg     <= '0;
            hex0        <= 7'b1000000;
            hex1        <= 7'b1000000;
            hex2        <= 7'b1000000;
            hex3        <= 7'b1000000;
            hex4        <= 7'b1000000;
            hex5        <= 7'b1000000;
            ovf         <= 3'b000;
            disp_update <= 1'b0;
        end else begin
            disp_update <= 1'b0;
            case (state)
                LOAD: begin
                    bin_reg <= port_sel;
                    bcd_reg <= '0;
                    counter <= '0;
                    state   <= SHIFT;
                end
                SHIFT: begin
                    bcd_reg <= {bcd_adj[10:0], bin_reg[CONV_BITS-1]};
                    bin_reg <= {bin_reg[CONV_BITS-2:0], 1'b0};
                    counter <= counter + 1'b1;
                    // Pulse is timed so it is high during the STORE cycle, alongside cur_port.
                    if (counter == LAST_SHIFT) begin
                        state       <= STORE;
                        disp_update <= 1'b1;
                    end
                end
                STORE: begin
                    case (cur_port)
                        2'd0: begin
                            hex1   <= seg_tens;
                            hex0   <= seg_ones;
                            ovf[0] <= hundreds_nz;
                        end
                        2'd1: begin
                            hex3   <= seg_tens;
                            hex2   <= seg_ones;
                            ovf[1] <= hundreds_nz;
                        end
                        2'd2: begin
                            hex5   <= seg_tens;
                            hex4   <= seg_ones;
                            ovf[2] <= hundreds_nz;
                        end
                        default: ;
                    endcase
                    cur_port <= (cur_port == LAST_PORT) ? 2'd0 : cur_port + 2'd1;
                    state    <= LOAD;
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_sc_io_hex_display.sv
// Self-checking bench for sc_io_hex_display: a cycle-level schedule model (10 cycles
// per port, sample in the first, publish in the last) checks every output every cycle.
module tb_sc_io_hex_display;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] port_val [3];
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
    logic [2:0]  ovf;
    logic        disp_update;
    logic [1:0]  cur_port;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit          model_valid = 1'b0;
    int          k = 0;
    int          sampled [3];
    logic [6:0]  m_hex [6];
    logic [2:0]  m_ovf;

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    always #5 clock = ~clock;

    sc_io_hex_display dut (
        .clock      (clock),
        .reset      (reset),
        .out_port0  (port_val[0]),
        .out_port1  (port_val[1]),
        .out_port2  (port_val[2]),
        .hex0       (hex0),
        .hex1       (hex1),
        .hex2       (hex2),
        .hex3       (hex3),
        .hex4       (hex4),
        .hex5       (hex5),
        .ovf        (ovf),
        .disp_update(disp_update),
        .cur_port   (cur_port)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_output();
        if (model_valid) begin
            check("hex0", {25'd0, hex0}, {25'd0, m_hex[0]});
            check("hex1", {25'd0, hex1}, {25'd0, m_hex[1]});
            check("hex2", {25'd0, hex2}, {25'd0, m_hex[2]});
            check("hex3", {25'd0, hex3}, {25'd0, m_hex[3]});
            check("hex4", {25'd0, hex4}, {25'd0, m_hex[4]});
            check("hex5", {25'd0, hex5}, {25'd0, m_hex[5]});
            check("ovf", {29'd0, ovf}, {29'd0, m_ovf});
            check("disp_update", {31'd0, disp_update}, ((k % 10) == 9) ? 32'd1 : 32'd0);
            check("cur_port", {30'd0, cur_port}, 32'((k / 10) % 3));
        end
    endtask

    // Called at a falling edge once inputs for this cycle are set: checks, models the
    // coming rising edge, then advances to the next falling edge.
    task automatic apply_stimulus();
        int phase, port, v;
        check_output();
        if (reset) begin
            for (int i = 0; i < 6; i++) m_hex[i] = 7'b1000000;
            m_ovf       = 3'b000;
            k           = 0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            phase = k % 10;
            port  = (k / 10) % 3;
            if (phase == 0) sampled[port] = int'(port_val[port][7:0]);
            if (phase == 9) begin
                v = sampled[port];
                m_hex[2*port]   = seg_tab[v % 10];
                m_hex[2*port+1] = seg_tab[(v / 10) % 10];
                m_ovf[port]     = (v >= 100);
            end
            k = (k + 1) % 30;
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) apply_stimulus();
    endtask

    task automatic wait_first_update(input string tag);
        int n = 1;
        while (disp_update !== 1'b1 && n < 20) begin
            apply_stimulus();
            n++;
        end
        check({tag, "_cycle"}, 32'(n), 32'd10);
        check({tag, "_port"}, {30'd0, cur_port}, 32'd0);
    endtask

    task automatic wait_phase(input int target, input string tag);
        int guard = 0;
        while (k != target && guard < 40) begin
            apply_stimulus();
            guard++;
        end
        check(tag, 32'(k), 32'(target));
    endtask

    initial begin
        int n;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) port_val[i] = 32'd0;
        @(negedge clock);

        run(3);
        check("rst_hex0", {25'd0, hex0}, {25'd0, 7'b1000000});
        check("rst_hex5", {25'd0, hex5}, {25'd0, 7'b1000000});
        check("rst_ovf", {29'd0, ovf}, 32'd0);
        check("rst_disp", {31'd0, disp_update}, 32'd0);
        reset = 1'b0;
        wait_first_update("first_update");

        port_val[0] = 32'h0000002A;
        run(40);
        check("p0_42_tens", {25'd0, hex1}, {25'd0, 7'b0011001});
        check("p0_42_ones", {25'd0, hex0}, {25'd0, 7'b0100100});
        check("p0_42_ovf", {31'd0, ovf[0]}, 32'd0);

        port_val[1] = 32'h000000FF;
        run(40);
        check("p1_255_tens", {25'd0, hex3}, {25'd0, 7'b0010010});
        check("p1_255_ones", {25'd0, hex2}, {25'd0, 7'b0010010});
        check("p1_255_ovf", {31'd0, ovf[1]}, 32'd1);

        port_val[1] = 32'h00000064;
        run(40);
        check("p1_100_tens", {25'd0, hex3}, {25'd0, 7'b1000000});
        check("p1_100_ones", {25'd0, hex2}, {25'd0, 7'b1000000});
        check("p1_100_ovf", {31'd0, ovf[1]}, 32'd1);

        port_val[2] = 32'hFFFFFF09;
        run(40);
        check("p2_09_tens", {25'd0, hex5}, {25'd0, 7'b1000000});
        check("p2_09_ones", {25'd0, hex4}, {25'd0, 7'b0010000});
        check("p2_09_ovf", {31'd0, ovf[2]}, 32'd0);

        // Change port 0 in the cycle after its LOAD: the next sample is 29 cycles
        // later and the result is published 9 cycles after that.
        wait_phase(1, "sync_after_load0");
        port_val[0] = 32'd7;
        n = 0;
        while (hex0 !== 7'b1111000 && n < 60) begin
            apply_stimulus();
            n++;
        end
        check("latency_hex0", 32'(n), 32'd39);

        // Reset in the 4th SHIFT cycle of port 1.
        wait_phase(14, "sync_shift4_port1");
        reset = 1'b1;
        apply_stimulus();
        reset = 1'b0;
        check("midrst_hex0", {25'd0, hex0}, {25'd0, 7'b1000000});
        check("midrst_hex3", {25'd0, hex3}, {25'd0, 7'b1000000});
        check("midrst_ovf", {29'd0, ovf}, 32'd0);
        check("midrst_port", {30'd0, cur_port}, 32'd0);
        wait_first_update("restart_update");

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0)
                port_val[$urandom_range(0, 2)] = $urandom;
            reset = ($urandom_range(0, 149) == 0);
            apply_stimulus();
        end
        reset = 1'b0;
        run(40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
